// File: rtl/tx_serial_fifo.sv
// Framed serial transmitter with a small word FIFO in front of it.
// Start bit, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
module tx_serial_fifo #(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              send,
    input  logic [DATA_W-1:0] palavra,
    output logic              busy,
    output logic              linha,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int DIV_W    = $clog2(STOP_LEN + 1);
    localparam int BIT_W    = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] STOP_LAST = DIV_W'(STOP_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_out(input logic acc);
        return acc ^ (PARITY_ODD != 0);
    endfunction

    state_t              state_r;
    logic                send_prev_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_next_s;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   shreg_r;
    logic                par_r;
    logic [DIV_W-1:0]    div_r;
    logic [BIT_W-1:0]    bitcnt_r;
    logic                push_req_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                bit_end_s;
    logic                stop_end_s;
    logic [DATA_W-1:0]   head_s;

    // Push/pop decisions and next occupancy; full is judged before any pop.
    always_comb begin
        push_req_s = send & ~send_prev_r;
        full_s     = (count_r == DEPTH_C);
        push_s     = push_req_s & ~full_s;
        bit_end_s  = (div_r == BIT_LAST);
        stop_end_s = (div_r == STOP_LAST);
        head_s     = mem_r[rd_ptr_r];
        pop_s      = 1'b0;
        case (state_r)
            IDLE:    pop_s = (count_r != CNT_ZERO);
            STOP:    pop_s = stop_end_s && (count_r != CNT_ZERO);
            default: pop_s = 1'b0;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and the full/overflow flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            send_prev_r <= 1'b0;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            full        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            send_prev_r <= send;
            if (push_s) begin
                mem_r[wr_ptr_r] <= palavra;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r  <= count_next_s;
            full     <= (count_next_s == DEPTH_C);
            overflow <= push_req_s & full_s;
        end
    end

    // Frame sequencer; linha follows the state one cycle later, busy covers the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            shreg_r  <= {DATA_W{1'b0}};
            par_r    <= 1'b0;
            div_r    <= DIV_ZERO;
            bitcnt_r <= BIT_ZERO;
            linha    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= (count_next_s != CNT_ZERO) || (state_r != IDLE) || pop_s;
            case (state_r)
                IDLE: begin
                    linha <= 1'b1;
                    div_r <= DIV_ZERO;
                    if (pop_s) begin
                        shreg_r  <= head_s;
                        par_r    <= 1'b0;
                        bitcnt_r <= BIT_ZERO;
                        state_r  <= START;
                    end
                end
                START: begin
                    linha <= 1'b0;
                    if (bit_end_s) begin
                        div_r   <= DIV_ZERO;
                        state_r <= DATA;
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                DATA: begin
                    linha <= shreg_r[0];
                    if (bit_end_s) begin
                        div_r   <= DIV_ZERO;
                        shreg_r <= shreg_r >> 1'b1;
                        par_r   <= par_r ^ shreg_r[0];
                        if (bitcnt_r == BITS_LAST) begin
                            state_r <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bitcnt_r <= bitcnt_r + BIT_ONE;
                        end
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                PARITY: begin
                    linha <= parity_out(par_r);
                    if (bit_end_s) begin
                        div_r   <= DIV_ZERO;
                        state_r <= STOP;
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                STOP: begin
                    linha <= 1'b1;
                    if (stop_end_s) begin
                        div_r <= DIV_ZERO;
                        // Queued word goes straight to a new start bit, no idle gap.
                        if (pop_s) begin
                            shreg_r  <= head_s;
                            par_r    <= 1'b0;
                            bitcnt_r <= BIT_ZERO;
                            state_r  <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                default: begin
                    linha   <= 1'b1;
                    div_r   <= DIV_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_serial_fifo.sv
// Directed bench for tx_serial_fifo: three instances cover even parity,
// odd parity, and the slow two-stop-bit configuration without parity.
module tb_tx_serial_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        send0, send1, send2;
    logic [15:0] pal0, pal1, pal2;
    logic        busy0, linha0, full0, ovf0;
    logic        busy1, linha1, full1, ovf1;
    logic        busy2, linha2, full2, ovf2;
    logic [56:0] e57;
    logic [18:0] e19;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    tx_serial_fifo #(.DATA_W(16), .CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clock(clock), .reset(reset), .send(send0), .palavra(pal0),
        .busy(busy0), .linha(linha0), .full(full0), .overflow(ovf0));

    tx_serial_fifo #(.DATA_W(16), .CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clock(clock), .reset(reset), .send(send1), .palavra(pal1),
        .busy(busy1), .linha(linha1), .full(full1), .overflow(ovf1));

    tx_serial_fifo #(.DATA_W(16), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clock(clock), .reset(reset), .send(send2), .palavra(pal2),
        .busy(busy2), .linha(linha2), .full(full2), .overflow(ovf2));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on u0 (and u1 in parallel); e[0] is the start bit, e[18] the stop bit.
    task automatic run_frames(input logic [18:0] e0, input logic [18:0] e1,
                              input int hold, input string tag);
        for (int c = 0; c < 21; c++) begin
            if (c == hold) begin
                send0 = 1'b0;
                send1 = 1'b0;
            end
            step();
            if (c == 0) begin
                chk({tag, "_busy_rise"}, busy0, 1'b1);
            end else if (c == 1) begin
                chk({tag, "_latency"}, linha0, 1'b1);
            end else begin
                chk($sformatf("%s_l0_%0d", tag, c - 2), linha0, e0[c-2]);
                chk($sformatf("%s_l1_%0d", tag, c - 2), linha1, e1[c-2]);
                chk($sformatf("%s_busy_%0d", tag, c - 2), busy0, 1'b1);
            end
        end
        step();
        chk({tag, "_busy0_fall"}, busy0, 1'b0);
        chk({tag, "_busy1_fall"}, busy1, 1'b0);
        chk({tag, "_idle_line"}, linha0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        send0 = 1'b0; send1 = 1'b0; send2 = 1'b0;
        pal0 = 16'h0000; pal1 = 16'h0000; pal2 = 16'h0000;
        step();
        step();
        chk("rst_linha", linha0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_full", full0, 1'b0);
        chk("rst_ovf", ovf0, 1'b0);
        chk("rst_linha2", linha2, 1'b1);
        reset = 1'b0;
        step();

        // Single word ABCD, even parity 0.
        pal0 = 16'hABCD;
        send0 = 1'b1;
        run_frames({1'b1, 1'b0, 16'hABCD, 1'b0}, 19'h7FFFF, 1, "abcd");

        // Level held 5 cycles: one frame; even parity 1, odd parity 0.
        pal0 = 16'h0001; pal1 = 16'h0001;
        send0 = 1'b1; send1 = 1'b1;
        run_frames({1'b1, 1'b1, 16'h0001, 1'b0}, {1'b1, 1'b0, 16'h0001, 1'b0}, 5, "hold");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_quiet_l_%0d", i), linha0, 1'b1);
            chk($sformatf("hold_quiet_b_%0d", i), busy0, 1'b0);
        end

        // Three pulses: back-to-back frames, busy continuous.
        e57 = {1'b1, 1'b0, 16'hFFFF, 1'b0,
               1'b1, 1'b1, 16'h1234, 1'b0,
               1'b1, 1'b0, 16'h5555, 1'b0};
        for (int c = 0; c < 59; c++) begin
            send0 = (c == 0) || (c == 2) || (c == 4);
            pal0  = (c == 0) ? 16'h5555 : ((c == 2) ? 16'h1234 : 16'hFFFF);
            step();
            if (c >= 1) chk($sformatf("b2b_busy_%0d", c), busy0, 1'b1);
            if (c >= 2) chk($sformatf("b2b_l_%0d", c - 2), linha0, e57[c-2]);
        end
        step();
        chk("b2b_busy_fall", busy0, 1'b0);
        chk("b2b_idle", linha0, 1'b1);

        // Six pushes of zero words, the sixth overflows; five frames follow.
        for (int c = 0; c < 98; c++) begin
            send0 = (c <= 10) && ((c % 2) == 0);
            pal0  = (c == 10) ? 16'hFFFF : 16'h0000;
            step();
            if (c == 7)  chk("ovf_full_before", full0, 1'b0);
            if (c == 8)  chk("ovf_full_after5", full0, 1'b1);
            if (c == 9)  chk("ovf_pre", ovf0, 1'b0);
            if (c == 10) chk("ovf_pulse", ovf0, 1'b1);
            if (c == 10) chk("ovf_full_hold", full0, 1'b1);
            if (c == 11) chk("ovf_clear", ovf0, 1'b0);
            if (c >= 2 && c <= 96) begin
                chk($sformatf("ovf_l_%0d", c - 2), linha0, ((c - 2) % 19) == 18);
                chk($sformatf("ovf_busy_%0d", c - 2), busy0, 1'b1);
            end
            if (c == 97) chk("ovf_five_frames", busy0, 1'b0);
        end

        // CLK_DIV=4, two stop bits, no parity: 76-cycle frame.
        e19 = {1'b1, 1'b1, 16'h8001, 1'b0};
        pal2 = 16'h8001;
        for (int c = 0; c < 79; c++) begin
            send2 = (c == 0);
            step();
            if (c == 1) chk("div4_latency", linha2, 1'b1);
            if (c >= 2 && c < 78) begin
                chk($sformatf("div4_l_%0d", c - 2), linha2, e19[(c-2)/4]);
                chk($sformatf("div4_busy_%0d", c - 2), busy2, 1'b1);
            end
            if (c == 78) begin
                chk("div4_busy_fall", busy2, 1'b0);
                chk("div4_idle", linha2, 1'b1);
            end
        end

        // Reset during data bit 7 with two words queued.
        for (int c = 0; c < 11; c++) begin
            send0 = (c == 0) || (c == 2) || (c == 4);
            pal0  = (c == 0) ? 16'h0080 : ((c == 2) ? 16'h1111 : 16'h2222);
            step();
            if (c == 9)  chk("mid_bit6", linha0, 1'b0);
            if (c == 10) chk("mid_bit7", linha0, 1'b1);
            if (c == 10) chk("mid_busy", busy0, 1'b1);
        end
        reset = 1'b1;
        step();
        chk("mid_rst_linha", linha0, 1'b1);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_full", full0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            chk($sformatf("mid_quiet_l_%0d", i), linha0, 1'b1);
            chk($sformatf("mid_quiet_b_%0d", i), busy0, 1'b0);
        end
        pal0 = 16'h00FF;
        send0 = 1'b1;
        run_frames({1'b1, 1'b0, 16'h00FF, 1'b0}, 19'h7FFFF, 1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
